alu_op_sequencer: RTL and testbench

- Hardware initiator for the ALU datapath.
- Accepts operation requests (A, B, ALU_Sel) on a valid/ready port and buffers them in a small FIFO.
- Issues one operation at a time on the ALU input bus, waits the ALU latency, then captures Result and flags.
- Returns a response on a valid/ready port. Sits between the command source and the ALU as the ALU's driving end.

---
 rtl/alu_seq_pkg.sv | 43 ++++
 rtl/alu_seq_fifo.sv | 61 ++++++
 rtl/alu_op_sequencer.sv | 174 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operation sequencer: FSM encodings, request
// entry and response flag layout.
package alu_seq_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_SEL_W  = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic [ALU_SEL_W-1:0]  sel;
  } req_t;

  // Packed so that the bit order matches rsp_flags {Zero,Carry,Overflow,Negative}
  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic negative;
  } flags_t;

  localparam int FLAG_ZERO_BIT     = 3;
  localparam int FLAG_CARRY_BIT    = 2;
  localparam int FLAG_OVERFLOW_BIT = 1;
  localparam int FLAG_NEGATIVE_BIT = 0;

  function automatic flags_t pack_flags(input logic z, input logic c,
                                        input logic v, input logic n);
    flags_t f;
    f.zero     = z;
    f.carry    = c;
    f.overflow = v;
    f.negative = n;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous request FIFO for the ALU sequencer; power-of-two depth,
// asynchronous active-low reset flushes the pointers and occupancy.
module alu_seq_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  req_t wdata_i,
  input  logic pop_i,
  output req_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = $clog2(DEPTH);

  req_t          mem_q [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [PW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  // Fullness is judged on the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + PW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives the ALU one queued operation at a time and returns Result/flags.
// Optional statistics counters are enabled with ALU_OP_SEQUENCER_STATS_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = ALU_DATA_W,
  parameter int SEL_W   = ALU_SEL_W,
  parameter int ALU_LAT = 1,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [SEL_W-1:0]  req_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              alu_negative,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
`ifdef ALU_OP_SEQUENCER_STATS_EN
  output logic [15:0]       ops_done,
  output logic [15:0]       ovf_count,
`endif
  output logic              busy
);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  req_t              alu_q, alu_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  flags_t            rsp_flags_q, rsp_flags_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              ready_q;

  req_t              push_data;
  req_t              head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;

  assign push_data.a   = req_a;
  assign push_data.b   = req_b;
  assign push_data.sel = req_sel;

  // ready_q keeps req_ready low while reset is held and for the release edge
  assign req_ready = ready_q && !fifo_full;
  assign fifo_push = req_valid && req_ready;

  alu_seq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (fifo_push),
    .wdata_i(push_data),
    .pop_i  (fifo_pop),
    .rdata_o(head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_d        = alu_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_valid_d  = rsp_valid_q;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          alu_d    = head;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = 4'(ALU_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_result_d = alu_result;
          rsp_flags_d  = pack_flags(alu_zero, alu_carry, alu_overflow, alu_negative);
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        // Back-to-back issue straight from the response handshake
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            alu_d    = head;
            state_d  = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      alu_q        <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_valid_q  <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_q        <= alu_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_valid_q  <= rsp_valid_d;
      ready_q      <= 1'b1;
    end
  end

  assign alu_a      = alu_q.a;
  assign alu_b      = alu_q.b;
  assign alu_sel    = alu_q.sel;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

`ifdef ALU_OP_SEQUENCER_STATS_EN
  logic [15:0] ops_done_q;
  logic [15:0] ovf_count_q;
  logic        rsp_hs;

  assign rsp_hs = rsp_valid_q && rsp_ready;

  // Both counters saturate instead of wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ops_done_q  <= '0;
      ovf_count_q <= '0;
    end else if (rsp_hs) begin
      if (ops_done_q != 16'hFFFF) begin
        ops_done_q <= ops_done_q + 16'd1;
      end
      if (rsp_flags_q.overflow && (ovf_count_q != 16'hFFFF)) begin
        ovf_count_q <= ovf_count_q + 16'd1;
      end
    end
  end

  assign ops_done  = ops_done_q;
  assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a combinational ADD-only ALU model.
// Stats checks are compiled when ALU_OP_SEQUENCER_STATS_EN is defined.
module tb_alu_op_sequencer;

  localparam int DATA_W  = 8;
  localparam int SEL_W   = 4;
  localparam int ALU_LAT = 1;
  localparam int DEPTH   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [SEL_W-1:0]  req_sel;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [SEL_W-1:0]  alu_sel;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_carry;
  logic              alu_overflow;
  logic              alu_negative;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [3:0]        rsp_flags;
  logic              busy;
`ifdef ALU_OP_SEQUENCER_STATS_EN
  logic [15:0]       ops_done;
  logic [15:0]       ovf_count;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W),
    .ALU_LAT(ALU_LAT),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_sel     (req_sel),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .alu_carry   (alu_carry),
    .alu_overflow(alu_overflow),
    .alu_negative(alu_negative),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags),
`ifdef ALU_OP_SEQUENCER_STATS_EN
    .ops_done    (ops_done),
    .ovf_count   (ovf_count),
`endif
    .busy        (busy)
  );

  // The ALU on the far side of the bus: an 8-bit adder with standard flags
  logic [DATA_W:0] aluSum;
  always_comb begin
    aluSum       = {1'b0, alu_a} + {1'b0, alu_b};
    alu_result   = aluSum[DATA_W-1:0];
    alu_zero     = (aluSum[DATA_W-1:0] == '0);
    alu_carry    = aluSum[DATA_W];
    alu_overflow = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                   (aluSum[DATA_W-1] != alu_a[DATA_W-1]);
    alu_negative = aluSum[DATA_W-1];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge,
  // leaving req_valid asserted so consecutive calls push back-to-back.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] sel);
    int n;
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_sel   = sel;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("push_accept", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic runSingle(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] expRes, input logic [3:0] expFlags);
    applyStimulus(a, b, 4'h0);
    req_valid = 1'b0;
    repeat (ALU_LAT + 1) @(negedge clk);
    checkOutput({tag, "_early"}, {31'd0, rsp_valid}, 32'd0);
    checkOutput({tag, "_alu_a"}, {24'd0, alu_a}, {24'd0, a});
    @(negedge clk);
    checkOutput({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    checkOutput({tag, "_result"}, {24'd0, rsp_result}, {24'd0, expRes});
    checkOutput({tag, "_flags"}, {28'd0, rsp_flags}, {28'd0, expFlags});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput({tag, "_done"}, {31'd0, rsp_valid}, 32'd0);
    checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  logic [7:0] qA   [6];
  logic [7:0] qRes [6];
  int         got;
  int         cyc;
  logic       sent6;
  logic       acc6;
  logic       sawValid;

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_alu_bus", {12'd0, alu_a, alu_b, alu_sel}, 32'd0);
    checkOutput("rst_rsp", {20'd0, rsp_result, rsp_flags}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rel_req_ready", {31'd0, req_ready}, 32'd1);

    // Single operations
    runSingle("add_05_03", 8'h05, 8'h03, 8'h08, 4'b0000);
    runSingle("add_ff_01", 8'hFF, 8'h01, 8'h00, 4'b1100);
    runSingle("add_7f_01", 8'h7F, 8'h01, 8'h80, 4'b0011);
`ifdef ALU_OP_SEQUENCER_STATS_EN
    checkOutput("stats_ops_done", {16'd0, ops_done}, 32'd3);
    checkOutput("stats_ovf_count", {16'd0, ovf_count}, 32'd1);
`endif

    // Backpressure: one op held in RESP plus a full FIFO
    qA[0] = 8'h10; qRes[0] = 8'h11;
    qA[1] = 8'h20; qRes[1] = 8'h21;
    qA[2] = 8'h30; qRes[2] = 8'h31;
    qA[3] = 8'h40; qRes[3] = 8'h41;
    qA[4] = 8'h50; qRes[4] = 8'h51;
    qA[5] = 8'h60; qRes[5] = 8'h61;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(qA[i], 8'h01, 4'h0);
    end
    req_a = qA[5];
    checkOutput("full_req_ready", {31'd0, req_ready}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("full_hold_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("full_busy", {31'd0, busy}, 32'd1);
    checkOutput("full_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("full_rsp_head", {24'd0, rsp_result}, 32'h11);

    rsp_ready = 1'b1;
    got   = 0;
    cyc   = 0;
    sent6 = 1'b0;
    acc6  = 1'b0;
    while (got < 6 && cyc < 200) begin
      if (acc6) req_valid = 1'b0;
      if (req_valid && req_ready) begin
        acc6  = 1'b1;
        sent6 = 1'b1;
      end
      if (rsp_valid) begin
        checkOutput($sformatf("order_%0d", got), {24'd0, rsp_result}, {24'd0, qRes[got]});
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    checkOutput("order_count", got, 32'd6);
    checkOutput("sixth_accepted", {31'd0, sent6}, 32'd1);
    checkOutput("drain_idle", {31'd0, busy}, 32'd0);

    // Reset while in WAIT with two requests queued
    applyStimulus(8'h21, 8'h02, 4'h0);
    applyStimulus(8'h22, 8'h02, 4'h0);
    applyStimulus(8'h23, 8'h02, 4'h0);
    req_valid = 1'b0;
    checkOutput("midop_busy", {31'd0, busy}, 32'd1);
    checkOutput("midop_alu_a", {24'd0, alu_a}, 32'h21);
    checkOutput("midop_no_rsp", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("midrst_alu_bus", {12'd0, alu_a, alu_b, alu_sel}, 32'd0);
    checkOutput("midrst_rsp", {20'd0, rsp_result, rsp_flags}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrel_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("midrel_busy", {31'd0, busy}, 32'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid || busy) sawValid = 1'b1;
      @(negedge clk);
    end
    checkOutput("midrel_no_rsp", {31'd0, sawValid}, 32'd0);

    // Sequencer still works after the mid-op reset
    runSingle("post_rst", 8'h12, 8'h34, 8'h46, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
